// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL counter family: direction encoding and the
// per-direction terminal-count value.
package ttl_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Terminal count is all-ones when counting up and zero when counting down.
  function automatic logic [31:0] terminal(input logic dir, input int unsigned width);
    if (dir == DIR_DOWN) begin
      return 32'd0;
    end
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ls191_if.sv
// Data/control bundle of one ls191 stage; master drives controls, slave is the counter.
interface ls191_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             n_load;
  logic             n_cten;
  logic             d_u;
  logic [WIDTH-1:0] q;
  logic             max_min;
  logic             n_rco;

  modport master (
    output din, n_load, n_cten, d_u,
    input  q, max_min, n_rco
  );

  modport slave (
    input  din, n_load, n_cten, d_u,
    output q, max_min, n_rco
  );
endinterface

// File: rtl/ls191_x2.sv
// Two ls191 stages cascaded n_rco -> n_cten to form an 8-bit synchronous counter.
module ls191_x2 (
  input  logic       clk,
  input  logic       n_clr,
  input  logic [7:0] din,
  input  logic       n_load,
  input  logic       n_cten,
  input  logic       d_u,
  output logic [7:0] q,
  output logic       max_min_lo,
  output logic       max_min_hi,
  output logic       n_rco
);

  ls191_if #(.WIDTH(4)) lo_if ();
  ls191_if #(.WIDTH(4)) hi_if ();

  assign lo_if.din    = din[3:0];
  assign lo_if.n_load = n_load;
  assign lo_if.n_cten = n_cten;
  assign lo_if.d_u    = d_u;

  assign hi_if.din    = din[7:4];
  assign hi_if.n_load = n_load;
  assign hi_if.n_cten = lo_if.n_rco;
  assign hi_if.d_u    = d_u;

  ls191 #(.WIDTH(4)) u_lo (
    .clk   (clk),
    .n_clr (n_clr),
    .bus   (lo_if.slave)
  );

  ls191 #(.WIDTH(4)) u_hi (
    .clk   (clk),
    .n_clr (n_clr),
    .bus   (hi_if.slave)
  );

  assign q          = {hi_if.q, lo_if.q};
  assign max_min_lo = lo_if.max_min;
  assign max_min_hi = hi_if.max_min;
  assign n_rco      = hi_if.n_rco;

endmodule

// File: rtl/ls191.sv
// Synchronous up/down binary counter (74LS191 equivalent) with synchronous load
// and combinational terminal-count / ripple-carry outputs.
module ls191
  import ttl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic    clk,
  input logic    n_clr,
  ls191_if.slave bus
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] term;
  logic             max_min;

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      cnt_q <= '0;
    end else if (!bus.n_load) begin
      cnt_q <= bus.din;
    end else if (!bus.n_cten) begin
      if (bus.d_u == DIR_DOWN) begin
        cnt_q <= cnt_q - WIDTH'(1);
      end else begin
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

  // No clk-low gating on n_rco, unlike the original part.
  assign term        = WIDTH'(terminal(bus.d_u, WIDTH));
  assign max_min     = (cnt_q == term);
  assign bus.q       = cnt_q;
  assign bus.max_min = max_min;
  assign bus.n_rco   = ~(max_min & ~bus.n_cten);

endmodule

// File: tb/tb_ls191.sv
// Self-checking bench for ls191: directed vectors, hand sequences, cascade and
// randomized traffic against an arithmetic reference model.
module tb_ls191;

  logic clk;
  logic n_clr;
  int   tests;
  int   fails;

  ls191_if #(.WIDTH(4)) bus ();

  ls191 #(.WIDTH(4)) dut (
    .clk   (clk),
    .n_clr (n_clr),
    .bus   (bus.slave)
  );

  logic       x_n_clr, x_n_load, x_n_cten, x_d_u;
  logic [7:0] x_din, x_q;
  logic       x_mm_lo, x_mm_hi, x_n_rco;

  ls191_x2 dut_x2 (
    .clk        (clk),
    .n_clr      (x_n_clr),
    .din        (x_din),
    .n_load     (x_n_load),
    .n_cten     (x_n_cten),
    .d_u        (x_d_u),
    .q          (x_q),
    .max_min_lo (x_mm_lo),
    .max_min_hi (x_mm_hi),
    .n_rco      (x_n_rco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic ld, input logic cten, input logic du,
                       input logic [3:0] d);
    n_clr      = clr;
    bus.n_load = ld;
    bus.n_cten = cten;
    bus.d_u    = du;
    bus.din    = d;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       n_clr;
    logic       n_load;
    logic       n_cten;
    logic       d_u;
    logic [3:0] din;
    logic [3:0] q;
    logic       mm;
    logic       rco;
  } vec_t;

  vec_t vecs[17];

  // Reference model state.
  int  mq;
  bit  mvalid;
  int  exp_mm;
  int  exp_rco;

  initial begin
    tests  = 0;
    fails  = 0;
    mvalid = 1'b0;
    mq     = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    x_n_clr = 1'b1; x_n_load = 1'b1; x_n_cten = 1'b1; x_d_u = 1'b0; x_din = 8'h00;

    //          clr   load  cten  d_u   din    q     mm    rco
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hE, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h4, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hE, 4'hE, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};

    #1;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].n_clr, vecs[i].n_load, vecs[i].n_cten, vecs[i].d_u, vecs[i].din);
      edge_wait();
      chk($sformatf("vec%0d_q", i), int'(bus.q), int'(vecs[i].q));
      chk($sformatf("vec%0d_max_min", i), int'(bus.max_min), int'(vecs[i].mm));
      chk($sformatf("vec%0d_n_rco", i), int'(bus.n_rco), int'(vecs[i].rco));
    end

    // Reset then a full up-count lap with wrap.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    edge_wait();
    chk("up_reset_q", int'(bus.q), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      edge_wait();
      chk($sformatf("up%0d_q", i), int'(bus.q), i % 16);
      chk($sformatf("up%0d_max_min", i), int'(bus.max_min), (i % 16 == 15) ? 1 : 0);
      chk($sformatf("up%0d_n_rco", i), int'(bus.n_rco), (i % 16 == 15) ? 0 : 1);
    end

    // Enable acts on n_rco combinationally, before the next edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    edge_wait();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    #1;
    chk("en_hold_max_min", int'(bus.max_min), 1);
    chk("en_hold_n_rco", int'(bus.n_rco), 1);
    edge_wait();
    chk("en_hold_q", int'(bus.q), 0);
    bus.n_cten = 1'b0;
    #1;
    chk("en_comb_n_rco", int'(bus.n_rco), 0);
    edge_wait();
    chk("en_down_q", int'(bus.q), 15);

    // Direction flip is seen combinationally on max_min.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    edge_wait();
    chk("dir_up_at0_max_min", int'(bus.max_min), 0);
    bus.d_u = 1'b1;
    #1;
    chk("dir_down_at0_max_min", int'(bus.max_min), 1);

    // Cascade: 0F -> 10 -> 0F, then FF -> 00.
    x_n_load = 1'b0; x_din = 8'h0F; x_n_cten = 1'b1; x_d_u = 1'b0;
    edge_wait();
    chk("x2_load_q", int'(x_q), 8'h0F);
    x_n_load = 1'b1; x_n_cten = 1'b0;
    edge_wait();
    chk("x2_up_q", int'(x_q), 8'h10);
    x_d_u = 1'b1;
    edge_wait();
    chk("x2_down_q", int'(x_q), 8'h0F);
    x_n_load = 1'b0; x_din = 8'hFF; x_n_cten = 1'b1; x_d_u = 1'b0;
    edge_wait();
    x_n_load = 1'b1; x_n_cten = 1'b0;
    #1;
    chk("x2_ff_mm_lo", int'(x_mm_lo), 1);
    chk("x2_ff_mm_hi", int'(x_mm_hi), 1);
    chk("x2_ff_n_rco", int'(x_n_rco), 0);
    edge_wait();
    chk("x2_wrap_q", int'(x_q), 8'h00);

    // Randomized traffic against the arithmetic model; first cycle forces a reset.
    for (int i = 0; i < 400; i++) begin
      drive((i == 0) ? 1'b0 : ($urandom_range(15) != 0),
            ($urandom_range(7) != 0),
            ($urandom_range(3) == 0),
            1'($urandom_range(1)),
            4'($urandom_range(15)));
      #1;
      if (mvalid) begin
        exp_mm  = (bus.d_u ? (mq == 0) : (mq == 15)) ? 1 : 0;
        exp_rco = (exp_mm == 1 && bus.n_cten == 1'b0) ? 0 : 1;
        chk($sformatf("rnd%0d_q", i), int'(bus.q), mq);
        chk($sformatf("rnd%0d_max_min", i), int'(bus.max_min), exp_mm);
        chk($sformatf("rnd%0d_n_rco", i), int'(bus.n_rco), exp_rco);
      end
      @(posedge clk);
      if (!n_clr)           mq = 0;
      else if (!bus.n_load) mq = int'(bus.din);
      else if (!bus.n_cten) mq = bus.d_u ? (mq + 15) % 16 : (mq + 1) % 16;
      mvalid = 1'b1;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ls191.md
Name: ls191

Overview:
- Synchronous 4-bit up/down binary counter, TTL 74LS191 equivalent, for the TankBatt board re-implementation.
- Complements the existing up-only loadable counter: adds the down direction and a borrow/carry indication for cascading.
- Used for downward timing chains and position counters that must count toward zero.
- Cascades through max_min / n_rco into the next stage's n_cten.

Parameters:
- WIDTH, 4, counter width in bits. 4 matches the TTL part; other values keep identical semantics with max = 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_clr  input  1  synchronous active-low reset; clears the counter.
- din  input  WIDTH  parallel load data.
- n_load  input  1  active-low load; synchronous in this design, not asynchronous as on the TTL part.
- n_cten  input  1  active-low count enable.
- d_u  input  1  direction: 0 = count up, 1 = count down.
- q  output  WIDTH  counter value.
- max_min  output  1  terminal-count flag, combinational.
- n_rco  output  1  active-low ripple carry/borrow, combinational.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset n_clr is synchronous and active-low; it is sampled only on the rising edge of clk.
- Priority per rising edge of clk: n_clr=0 > n_load=0 > count > hold.
- Reset:
  - n_clr=0 gives q=0 on the next edge, regardless of n_load, n_cten and d_u.
  - Power-up/initial value of q is 0.
  - After reset, max_min follows d_u: max_min = d_u, because q=0 is the terminal count when counting down.
  - After reset, n_rco = ~(d_u & ~n_cten).
- Load: n_load=0 (and n_clr=1) gives q=din on the next edge. Load ignores n_cten and d_u.
- Count: n_clr=1, n_load=1, n_cten=0:
  - d_u=0: q <= q+1 modulo 2^WIDTH; max wraps to 0.
  - d_u=1: q <= q-1 modulo 2^WIDTH; 0 wraps to max.
- Hold: n_cten=1 (and no reset or load) keeps q unchanged.
- max_min:
  - 1 when (d_u=0 and q=max) or (d_u=1 and q=0), else 0.
  - Independent of n_cten.
  - Responds combinationally to a d_u change in the same cycle.
- n_rco = ~(max_min & ~n_cten). This is a purely combinational level with no clock gating; the original chip's clk-low gating is intentionally omitted.
- Direction change mid-count: legal on any cycle. The new d_u takes effect on the same edge it is sampled, with no dead cycle.
- Load of a terminal value: max_min asserts in the cycle after the load edge, e.g. load max with d_u=0.
- Reset during load or count: reset wins; q=0 on the next edge.
- Latency: q updates one edge after the control inputs are sampled. max_min and n_rco carry zero added latency from q, d_u and n_cten.
- Cascading: the stage-k n_rco drives the stage-(k+1) n_cten. All stages share clk and d_u, so the chain counts synchronously as one wide counter.

Decomposition:
- Shared package (ttl_pkg):
  - direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - a function returning the terminal value for a given direction and WIDTH.
- No sub-module: a single always block for the counter plus two continuous assigns for max_min and n_rco.
- A separate bench-only wrapper, ls191_x2, instantiates two cascaded stages to check 8-bit chaining.

Test Plan:
1. Reset, then count up:
   - Stimulus: n_clr=0 for one edge, then n_clr=1, n_load=1, n_cten=0, d_u=0 for 16 edges.
   - Required: q goes 0,1,…,15,0. max_min=1 and n_rco=0 only while q=15.
2. Count down with wrap:
   - Stimulus: after reset, d_u=1, n_cten=0.
   - Required: max_min=1 and n_rco=0 at q=0. Next edge q=15, then 14; max_min=0 from q=15 onward.
3. Load priority:
   - Stimulus: n_load=0, din=4'hA, n_cten=0, d_u=0.
   - Required: q=A next edge, with no increment. With n_clr=0 on the same edge, q=0 instead.
4. Enable and direction:
   - Stimulus: load 4'h0 with d_u=0; then d_u=1, n_cten=1.
   - Required: q holds at 0, max_min=1, n_rco=1.
   - Then n_cten=0: n_rco=0 immediately (combinational) and q=15 next edge.
5. Mid-count reversal:
   - Stimulus: from q=5 counting up, set d_u=1 for one edge, then back to 0.
   - Required: q goes 5→4→5. No glitch on max_min at non-terminal values.
6. Cascade (ls191_x2):
   - Stimulus: load 8'h0F up-count, one enabled edge.
   - Required: result 8'h10, with the high stage incrementing on the same edge.
   - Reverse from 8'h10 down: result 8'h0F.
   - 8'hFF up gives 8'h00, with both stages' max_min high beforehand.
